// File: rtl/cpu_defs_pkg.sv
// Shared encodings for the multi-cycle CPU control path:
// opcodes, ext codes, condition codes, FSM states and flag bit positions.
package cpu_defs_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [3:0] ALU_ADD = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b1001;
  localparam logic [3:0] ALU_CMP = 4'b1011;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_HI = 4'b0100;
  localparam logic [3:0] CC_LS = 4'b0101;
  localparam logic [3:0] CC_GT = 4'b0110;
  localparam logic [3:0] CC_LE = 4'b0111;
  localparam logic [3:0] CC_FS = 4'b1000;
  localparam logic [3:0] CC_FC = 4'b1001;
  localparam logic [3:0] CC_LO = 4'b1010;
  localparam logic [3:0] CC_HS = 4'b1011;
  localparam logic [3:0] CC_LT = 4'b1100;
  localparam logic [3:0] CC_GE = 4'b1101;
  localparam logic [3:0] CC_UC = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_LOAD, S_STORE, S_BRANCH
  } state_t;

  typedef enum logic [2:0] {
    K_ALU, K_IMM, K_LOAD, K_STORE, K_BRANCH, K_NOP
  } kind_t;

  function automatic kind_t decode_kind(
    input logic [3:0] op,
    input logic [3:0] ext
  );
    kind_t k;
    k = K_NOP;
    case (op)
      OP_RTYPE: k = K_ALU;
      OP_ANDI, OP_ORI, OP_XORI, OP_ADDI,
      OP_SUBI, OP_CMPI, OP_MOVI: k = K_IMM;
      OP_BCOND: k = K_BRANCH;
      OP_MEM: begin
        case (ext)
          EXT_LOAD:  k = K_LOAD;
          EXT_STOR:  k = K_STORE;
          EXT_JCOND: k = K_BRANCH;
          default:   k = K_NOP;
        endcase
      end
      default: k = K_NOP;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/cpu_control_fsm_branch_cond_eval.sv
// Branch condition evaluator: maps a 4-bit condition code and the
// {C,L,F,Z,N} flags to a taken bit.
module branch_cond_eval
  import cpu_defs_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken
);

  logic c, l, f, z, n;

  assign c = flags[FLAG_C];
  assign l = flags[FLAG_L];
  assign f = flags[FLAG_F];
  assign z = flags[FLAG_Z];
  assign n = flags[FLAG_N];

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      CC_EQ: taken = z;
      CC_NE: taken = ~z;
      CC_CS: taken = c;
      CC_CC: taken = ~c;
      CC_HI: taken = l;
      CC_LS: taken = ~l;
      CC_GT: taken = n;
      CC_LE: taken = ~n;
      CC_FS: taken = f;
      CC_FC: taken = ~f;
      CC_LO: taken = ~l & ~z;
      CC_HS: taken = l | z;
      CC_LT: taken = ~n & ~z;
      CC_GE: taken = n | z;
      CC_UC: taken = 1'b1;
      CC_NV: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control FSM: fetch, decode and sequence regfile, ALU,
// memory and PC strobes for the 16-bit datapath.
module cpu_control_fsm
  import cpu_defs_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NREGS    = 16,
  parameter int GAME_REG = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr,
  input  logic              mem_ready,
  input  logic [4:0]        flags,
  output logic [NREGS-1:0]  reg_en,
  output logic [3:0]        src_sel,
  output logic [3:0]        dst_sel,
  output logic [3:0]        alu_op,
  output logic              use_imm,
  output logic [7:0]        imm8,
  output logic              wb_sel,
  output logic              flags_en,
  output logic              mem_addr_sel,
  output logic              mem_we,
  output logic              ir_load,
  output logic              pc_en,
  output logic              pc_load
);

  state_t            state, next;
  logic [DATA_W-1:0] ir;
  kind_t             kind;
  logic [3:0]        ex_op;
  logic              is_arith;
  logic              dst_ok;
  logic [NREGS-1:0]  dst_hot;
  logic              taken;

  assign src_sel = ir[3:0];
  assign dst_sel = ir[11:8];
  assign imm8    = ir[7:0];

  assign kind     = decode_kind(ir[15:12], ir[7:4]);
  assign is_arith = (kind == K_ALU) || (kind == K_IMM);
  assign ex_op    = (kind == K_IMM) ? ir[15:12] : ir[7:4];
  assign dst_ok   = (ir[11:8] != 4'(GAME_REG));
  assign dst_hot  = {{(NREGS-1){1'b0}}, 1'b1} << ir[11:8];

  // Both Bcond and Jcond carry their condition in the Rdest slot
  branch_cond_eval u_cond (
    .cond  (ir[11:8]),
    .flags (flags),
    .taken (taken)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      ir    <= '0;
    end else begin
      state <= next;
      if (ir_load) ir <= instr;
    end
  end

  always_comb begin
    next         = state;
    reg_en       = '0;
    alu_op       = '0;
    use_imm      = 1'b0;
    wb_sel       = 1'b0;
    flags_en     = 1'b0;
    mem_addr_sel = 1'b0;
    mem_we       = 1'b0;
    ir_load      = 1'b0;
    pc_en        = 1'b0;
    pc_load      = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (mem_ready) begin
          ir_load = 1'b1;
          next    = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (kind)
          K_LOAD:   next = S_LOAD;
          K_STORE:  next = S_STORE;
          K_BRANCH: next = S_BRANCH;
          default:  next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        if (is_arith) begin
          alu_op   = ex_op;
          use_imm  = (kind == K_IMM);
          flags_en = (ex_op == ALU_ADD) ||
                     (ex_op == ALU_SUB) ||
                     (ex_op == ALU_CMP);
          if (dst_ok && ex_op != ALU_CMP) reg_en = dst_hot;
        end
        pc_en = 1'b1;
        next  = S_FETCH;
      end
      S_LOAD: begin
        mem_addr_sel = 1'b1;
        if (mem_ready) begin
          wb_sel = 1'b1;
          if (dst_ok) reg_en = dst_hot;
          pc_en  = 1'b1;
          next   = S_FETCH;
        end
      end
      S_STORE: begin
        mem_addr_sel = 1'b1;
        mem_we       = 1'b1;
        if (mem_ready) begin
          pc_en = 1'b1;
          next  = S_FETCH;
        end
      end
      S_BRANCH: begin
        pc_load = taken;
        pc_en   = ~taken;
        next    = S_FETCH;
      end
      default: next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed scoreboard bench for cpu_control_fsm: expected output bundles
// are queued per cycle and compared against the DUT mid-cycle.
module tb_cpu_control_fsm;

  typedef struct packed {
    logic [15:0] reg_en;
    logic [3:0]  src_sel;
    logic [3:0]  dst_sel;
    logic [3:0]  alu_op;
    logic        use_imm;
    logic [7:0]  imm8;
    logic        wb_sel;
    logic        flags_en;
    logic        mem_addr_sel;
    logic        mem_we;
    logic        ir_load;
    logic        pc_en;
    logic        pc_load;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        mem_ready;
  logic [4:0]  flags;
  logic [15:0] reg_en;
  logic [3:0]  src_sel, dst_sel, alu_op;
  logic        use_imm;
  logic [7:0]  imm8;
  logic        wb_sel, flags_en, mem_addr_sel, mem_we;
  logic        ir_load, pc_en, pc_load;

  obs_t        exp_q[$];
  string       tag_q[$];
  logic [15:0] cur_ir;
  int          n_assert = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  cpu_control_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .mem_ready    (mem_ready),
    .flags        (flags),
    .reg_en       (reg_en),
    .src_sel      (src_sel),
    .dst_sel      (dst_sel),
    .alu_op       (alu_op),
    .use_imm      (use_imm),
    .imm8         (imm8),
    .wb_sel       (wb_sel),
    .flags_en     (flags_en),
    .mem_addr_sel (mem_addr_sel),
    .mem_we       (mem_we),
    .ir_load      (ir_load),
    .pc_en        (pc_en),
    .pc_load      (pc_load)
  );

  function automatic obs_t base();
    obs_t e;
    e         = '0;
    e.src_sel = cur_ir[3:0];
    e.dst_sel = cur_ir[11:8];
    e.imm8    = cur_ir[7:0];
    return e;
  endfunction

  task automatic check();
    obs_t  o, e;
    string t;
    o = {reg_en, src_sel, dst_sel, alu_op, use_imm, imm8, wb_sel,
         flags_en, mem_addr_sel, mem_we, ir_load, pc_en, pc_load};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
    n_assert++;
    assert (!(pc_en && pc_load) && $onehot0(reg_en) && !reg_en[15])
    else begin
      n_fail++;
      $error("FAIL %s_invariant observed pc_en=%b pc_load=%b reg_en=%h expected exclusive/onehot0/no-r15",
             t, pc_en, pc_load, reg_en);
    end
  endtask

  // Drive one cycle's inputs, queue the expectation, compare, advance
  task automatic step(input string tag, input logic mr, input obs_t e);
    mem_ready = mr;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #3;
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [15:0] w);
    obs_t e;
    instr     = w;
    e         = base();
    e.ir_load = 1'b1;
    step({tag, "_fetch"}, 1'b1, e);
    cur_ir = w;
    step({tag, "_decode"}, 1'b0, base());
  endtask

  task automatic exec(input string tag, input logic [15:0] ren,
                      input logic [3:0] op, input logic imm,
                      input logic fen);
    obs_t e;
    e          = base();
    e.reg_en   = ren;
    e.alu_op   = op;
    e.use_imm  = imm;
    e.flags_en = fen;
    e.pc_en    = 1'b1;
    step({tag, "_exec"}, 1'b0, e);
  endtask

  task automatic branch(input string tag, input logic tk);
    obs_t e;
    e         = base();
    e.pc_load = tk;
    e.pc_en   = ~tk;
    step({tag, "_branch"}, 1'b0, e);
  endtask

  initial begin
    obs_t e;
    reset     = 1'b1;
    mem_ready = 1'b0;
    flags     = 5'b0;
    instr     = 16'h0;
    cur_ir    = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    step("reset_idle", 1'b0, base());

    fetch("add_r3_r1", 16'h0351);
    exec("add_r3_r1", 16'h0008, 4'b0101, 1'b0, 1'b1);

    fetch("movi_r15", 16'hDF2A);
    exec("movi_r15", 16'h0000, 4'b1101, 1'b1, 1'b0);

    fetch("cmpi_r2", 16'hB207);
    exec("cmpi_r2", 16'h0000, 4'b1011, 1'b1, 1'b1);

    fetch("addi_r6", 16'h5603);
    exec("addi_r6", 16'h0040, 4'b0101, 1'b1, 1'b1);

    fetch("and_r1_r2", 16'h0112);
    exec("and_r1_r2", 16'h0002, 4'b0001, 1'b0, 1'b0);

    fetch("nop_6123", 16'h6123);
    exec("nop_6123", 16'h0000, 4'b0000, 1'b0, 1'b0);

    step("fetch_wait", 1'b0, base());
    fetch("load_r4", 16'h4402);
    e = base();
    e.mem_addr_sel = 1'b1;
    step("load_wait1", 1'b0, e);
    step("load_wait2", 1'b0, e);
    e.wb_sel = 1'b1;
    e.reg_en = 16'h0010;
    e.pc_en  = 1'b1;
    step("load_done", 1'b1, e);

    fetch("load_r15", 16'h4F00);
    e = base();
    e.mem_addr_sel = 1'b1;
    e.wb_sel       = 1'b1;
    e.pc_en        = 1'b1;
    step("load_r15_done", 1'b1, e);

    flags = 5'b00010;
    fetch("beq_z1", 16'hC0FE);
    branch("beq_z1", 1'b1);
    flags = 5'b11101;
    fetch("beq_z0", 16'hC0FE);
    branch("beq_z0", 1'b0);
    flags = 5'b00000;
    fetch("buc", 16'hCE10);
    branch("buc", 1'b1);
    flags = 5'b11111;
    fetch("bnv", 16'hCF10);
    branch("bnv", 1'b0);
    flags = 5'b01111;
    fetch("jcc_c0", 16'h43C5);
    branch("jcc_c0", 1'b1);
    flags = 5'b00010;
    fetch("blt_z1", 16'hCC02);
    branch("blt_z1", 1'b0);
    flags = 5'b00000;
    fetch("blo_l0z0", 16'hCA02);
    branch("blo_l0z0", 1'b1);

    fetch("stor_r1", 16'h4143);
    e = base();
    e.mem_addr_sel = 1'b1;
    e.mem_we       = 1'b1;
    step("stor_wait1", 1'b0, e);
    step("stor_wait2", 1'b0, e);
    e.pc_en = 1'b1;
    step("stor_done", 1'b1, e);
    step("stor_after", 1'b0, base());

    fetch("load_r7", 16'h4705);
    e = base();
    e.mem_addr_sel = 1'b1;
    step("midload_wait", 1'b0, e);
    reset = 1'b1;
    step("midload_reset", 1'b0, e);
    reset  = 1'b0;
    cur_ir = 16'h0;
    step("post_reset_fetch", 1'b0, base());
    fetch("post_reset_sub", 16'h0291);
    exec("post_reset_sub", 16'h0004, 4'b1001, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
Multi-cycle control state machine for the 16-bit datapath. It fetches an instruction, decodes it, and sequences the one-hot register-file write enables, ALU operation, immediate/writeback muxes, memory strobes and PC updates. It sits between the instruction/data memory port and the register-file/ALU datapath. Register 15 is the hardware game-input register, so the FSM never writes it.

Parameters:
DATA_W, 16, instruction and datapath word width
NREGS, 16, register count; width of reg_en
GAME_REG, 15, index of the read-only game-input register; its enable is never asserted

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
instr  input  16  instruction word from memory; valid when mem_ready=1 in FETCH
mem_ready  input  1  memory read/write complete this cycle
flags  input  5  {C,L,F,Z,N} from flag register
reg_en  output  16  one-hot register write enable (to regfile regEnable)
src_sel  output  4  Rsrc read select
dst_sel  output  4  Rdest read select
alu_op  output  4  ALU function code
use_imm  output  1  ALU B operand = sign-extended imm8
imm8  output  8  immediate/displacement field
wb_sel  output  1  0: ALU result to bus, 1: memory data to bus
flags_en  output  1  flag register load strobe
mem_addr_sel  output  1  0: address = PC, 1: address = R[src]
mem_we  output  1  data-memory write strobe
ir_load  output  1  instruction register load
pc_en  output  1  PC <= PC+1
pc_load  output  1  PC <= branch target (PC+disp or R[src])

Behaviour:
- Instruction fields are instr[15:12] op, [11:8] Rdest, [7:4] ext/cond, [3:0] Rsrc. The low byte [7:0] is imm8. The fields are latched with ir_load. All outputs are decoded combinationally from the state and the latched fields.
- Reset: state=FETCH, latched IR=0, and every output is 0 except during FETCH decode (see FETCH). A reset mid-instruction aborts it with no write.
- States: FETCH, DECODE, EXEC, LOAD, STORE, BRANCH.
- FETCH: mem_addr_sel=0. When mem_ready=1, drive ir_load=1 and go to DECODE; otherwise hold. No other strobes are asserted.
- DECODE: one cycle with no strobes.
  - op=0000 (R-type ALU, alu_op=ext) or op in {0101 ADDI, 1001 SUBI, 1011 CMPI, 1101 MOVI, 0001 ANDI, 0010 ORI, 0011 XORI} goes to EXEC. For the immediate forms, alu_op=op and use_imm=1.
  - op=0100 with ext=0000 (LOAD) goes to LOAD. ext=0100 (STOR) goes to STORE. ext=1100 (Jcond) goes to BRANCH.
  - op=1100 (Bcond, disp=imm8) goes to BRANCH.
  - Any other encoding is a NOP: go to EXEC with reg_en=0 and flags_en=0.
- EXEC: one cycle.
  - reg_en=1<<Rdest, except when Rdest=GAME_REG, the op is CMP/CMPI (alu op 1011), or the instruction is a NOP. In those cases reg_en=0.
  - flags_en=1 for ADD/SUB/CMP and their immediate forms; flags_en=0 otherwise.
  - pc_en=1, then go to FETCH.
- LOAD: mem_addr_sel=1. Wait while mem_ready=0. On mem_ready=1, drive wb_sel=1, reg_en=1<<Rdest (suppressed for GAME_REG) and pc_en=1, then go to FETCH.
- STORE: mem_addr_sel=1 and mem_we=1 until mem_ready=1. On that cycle also drive pc_en=1 and go to FETCH.
- BRANCH: one cycle. Condition codes:
  - EQ 0000 Z; NE 0001 ~Z; CS 0010 C; CC 0011 ~C; HI 0100 L; LS 0101 ~L.
  - GT 0110 N; LE 0111 ~N; FS 1000 F; FC 1001 ~F; LO 1010 ~L&~Z; HS 1011 L|Z.
  - LT 1100 ~N&~Z; GE 1101 N|Z; UC 1110 always; 1111 never.
  - If taken: pc_load=1 and pc_en=0. If not taken: pc_en=1. Then go to FETCH.
- pc_en and pc_load are never asserted together. reg_en is always zero-hot or one-hot. reg_en[GAME_REG] is always 0.
- Latency: ALU/NOP/branch instructions take 3 cycles. LOAD/STORE take 3 cycles plus memory wait cycles. FETCH adds its own wait cycles.

Decomposition:
- Shared package cpu_defs_pkg: opcode/ext constants, condition-code constants, state encoding, flag bit indices.
- Sub-module branch_cond_eval: combinational, inputs cond[3:0] and flags[4:0], output taken. It is reused by any future pipelined core.

Test Plan:
- Reset held mid-LOAD, then released -> next cycle state=FETCH; reg_en, mem_we, pc_en, pc_load are all 0; no register written.
- instr=0x0351 (ADD R3,R1), mem_ready=1 -> cycle 1 ir_load; cycle 3 reg_en=0x0008, alu_op=0101, flags_en=1, pc_en=1.
- instr=0xDF2A (MOVI R15,0x2A) -> EXEC shows reg_en=0x0000, pc_en=1. Also instr=0xB207 (CMPI R2,7) -> reg_en=0, flags_en=1.
- instr=0x4402 (LOAD R4,[R2]) with mem_ready low for 2 cycles in LOAD -> mem_addr_sel=1 for 3 cycles; reg_en=0x0010 and wb_sel=1 only on the mem_ready cycle.
- instr=0xC0FE (BEQ -2): flags Z=1 -> pc_load=1, pc_en=0; flags Z=0 -> pc_en=1, pc_load=0. Also cond 1110 is always taken and cond 1111 is never taken.
- instr=0x4143 (STOR R1,[R3]) -> mem_we=1 and mem_addr_sel=1 held until mem_ready; exactly one pc_en pulse; reg_en stays 0 throughout.
